// File: rtl/m_fifo_thr.sv
// rtl/m_fifo_thr.sv - synchronous FIFO, any depth >= 2, programmable thresholds, flush, protected push/pop
// Optional feature macro: FIFO_ERR_CHECK_EN (sticky overflow/underflow plus drop reporting)
module m_fifo_thr #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 5,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push_enable,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_enable,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] item_count,
  output logic                       full_flag,
  output logic                       empty_flag,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_acc;
  logic             pop_acc;

  // Occupancy flags derive only from the registered count
  always_comb begin
    full_flag    = (count_q == CNT_W'(DEPTH));
    empty_flag   = (count_q == '0);
    almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    item_count   = count_q;
    pop_data     = mem_q[rd_ptr_q];
  end

  // Accept rules: a push on full is legal only when a pop frees the head slot
  // in the same cycle; flush suppresses both operations
  always_comb begin
    push_acc = ~clear & push_enable & (~full_flag | pop_enable);
    pop_acc  = ~clear & pop_enable & ~empty_flag;
  end

  // Next-state for storage, wrap-around pointers and occupancy
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; memory is also reset so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef FIFO_ERR_CHECK_EN
  logic push_drop;
  logic pop_drop;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Dropped requests, ignoring those swallowed by a flush
  always_comb begin
    push_drop = ~clear & push_enable & ~push_acc;
    pop_drop  = ~clear & pop_enable & ~pop_acc;
  end

  // Sticky error bits, cleared only by flush or reset
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_drop) overflow_d  = 1'b1;
      if (pop_drop)  underflow_d = 1'b1;
    end
  end

  // Sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifndef SYNTHESIS
  // Report each dropped request at the edge where it is discarded
  always @(posedge clk) begin
    if (rst_n && push_drop) $info("PUSH ON FULL");
    if (rst_n && pop_drop)  $info("POP ON EMPTY");
  end
`endif
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_m_fifo_thr.sv
// tb/tb_m_fifo_thr.sv - directed self-checking bench for m_fifo_thr
module tb_m_fifo_thr;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
`ifdef FIFO_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             push_enable;
  logic [WIDTH-1:0] push_data;
  logic             pop_enable;
  logic [WIDTH-1:0] pop_data;
  logic [2:0]       item_count;
  logic             full_flag;
  logic             empty_flag;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  int checks;
  int failures;

  m_fifo_thr #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .push_enable(push_enable), .push_data(push_data),
    .pop_enable(pop_enable), .pop_data(pop_data),
    .item_count(item_count), .full_flag(full_flag), .empty_flag(empty_flag),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the edge with inputs idle
  task automatic step(input logic do_push, input logic [7:0] d, input logic do_pop, input logic do_clear);
    push_enable = do_push;
    push_data   = d;
    pop_enable  = do_pop;
    clear       = do_clear;
    @(posedge clk);
    #1;
    push_enable = 1'b0;
    pop_enable  = 1'b0;
    clear       = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    push_enable = 1'b0;
    push_data = '0;
    pop_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    check("rst_count", 32'(item_count), 0);
    check("rst_empty", 32'(empty_flag), 1);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_full", 32'(full_flag), 0);
    check("rst_af", 32'(almost_full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_udf", 32'(underflow), 0);
    check("rst_data", 32'(pop_data), 0);
    rst_n = 1'b1;

    // Fill 0x11..0x15
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
      check("fill_count", 32'(item_count), 32'(i + 1));
      check("fill_ae", 32'(almost_empty), 32'((i + 1) <= 1));
      check("fill_af", 32'(almost_full), 32'((i + 1) >= 4));
      check("fill_full", 32'(full_flag), 32'((i + 1) == 5));
      check("fill_head", 32'(pop_data), 32'h11);
    end

    // Drain in order
    for (int i = 0; i < 5; i++) begin
      check("drain_data", 32'(pop_data), 32'h11 + 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_count", 32'(item_count), 32'(4 - i));
    end
    check("drain_empty", 32'(empty_flag), 1);

    // Wrap: occupancy held at 2 over 12 words
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 8'h21, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) begin
      check("wrap_data", 32'(pop_data), 32'h20 + 32'(i - 2));
      step(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
      check("wrap_count", 32'(item_count), 2);
    end
    check("wrap_tail0", 32'(pop_data), 32'h2A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_tail1", 32'(pop_data), 32'h2B);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_empty", 32'(empty_flag), 1);

    // Full, then a lone push is dropped
    for (int i = 0; i < 5; i++) step(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
    check("full_flag", 32'(full_flag), 1);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_count", 32'(item_count), 5);
    check("ovf_flag", 32'(overflow), 32'(ERR_EN));
    check("ovf_head", 32'(pop_data), 32'h41);
    check("ovf_udf", 32'(underflow), 0);

    // Full with push+pop: both accepted, new word lands last
    check("fpp_head", 32'(pop_data), 32'h41);
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    check("fpp_count", 32'(item_count), 5);
    begin
      logic [7:0] exp_seq [5];
      exp_seq = '{8'h42, 8'h43, 8'h44, 8'h45, 8'hBB};
      for (int i = 0; i < 5; i++) begin
        check("fpp_data", 32'(pop_data), 32'(exp_seq[i]));
        step(1'b0, 8'h00, 1'b1, 1'b0);
      end
    end
    check("fpp_empty", 32'(empty_flag), 1);

    // Empty with push+pop: pop dropped, no bypass
    step(1'b1, 8'h33, 1'b1, 1'b0);
    check("epp_count", 32'(item_count), 1);
    check("epp_udf", 32'(underflow), 32'(ERR_EN));
    check("epp_data", 32'(pop_data), 32'h33);
    check("epp_ovf_sticky", 32'(overflow), 32'(ERR_EN));
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Clear with concurrent push at count 3
    for (int i = 0; i < 3; i++) step(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0);
    check("pre_clr_count", 32'(item_count), 3);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    check("clr_count", 32'(item_count), 0);
    check("clr_empty", 32'(empty_flag), 1);
    check("clr_ovf", 32'(overflow), 0);
    check("clr_udf", 32'(underflow), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pop_empty_count", 32'(item_count), 0);
    check("pop_empty_udf", 32'(underflow), 32'(ERR_EN));

    // Asynchronous reset between edges
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    check("pre_arst_count", 32'(item_count), 2);
    push_enable = 1'b1;
    push_data = 8'h63;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(item_count), 0);
    check("arst_empty", 32'(empty_flag), 1);
    check("arst_data", 32'(pop_data), 0);
    check("arst_udf", 32'(underflow), 0);
    push_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_arst_count", 32'(item_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
